// File: rtl/compare_arbiter.sv
// compare_arbiter
//   Shares one combinational signed 4-bit compare unit among NREQ requesters.
//   A transaction walks IDLE -> BUSY -> RESP -> IDLE: the winner's operands are
//   latched on the IDLE exit edge, presented to the shared unit during BUSY, and
//   the unit's answer is registered and returned, tagged with the requester
//   index, over a valid/ready response port.
//
//   Build option: define CMP_ARB_FIXED_PRIO_EN to replace round-robin
//   arbitration with fixed priority (lowest set req index wins, no pointer).
//
//   Response handshake: rsp_valid rises on the edge that closes BUSY and stays
//   high, with rsp_id/rsp_data unchanged, until a rising edge on which
//   rsp_ready is also high; that edge completes the transfer and drops
//   rsp_valid. rsp_ready may be held low indefinitely (no timeout).
//
//   fsm_state exposes the controller state (0 IDLE, 1 BUSY, 2 RESP) for
//   observation; it carries no functional meaning for the requesters.

module compare_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_bus,
  input  logic [4*NREQ-1:0] b_bus,
  input  logic [2*NREQ-1:0] op_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        cmp_a,
  output logic [3:0]        cmp_b,
  output logic [1:0]        cmp_op,
  input  logic [3:0]        cmp_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_data,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Control strobes decoded from the FSM for the datapath registers.
  logic take;    // IDLE edge with a winner: latch operands, raise gnt
  logic finish;  // BUSY edge: capture result, drop gnt, raise rsp_valid
  logic retire;  // RESP edge with rsp_ready: response consumed

  // Arbitration result for the current cycle.
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [NREQ-1:0] win_onehot;

  // Operands of the current winner, selected from the request buses.
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [1:0] sel_op;

  // Latched transaction context; drives the shared compare unit.
  logic [3:0]     lat_a;
  logic [3:0]     lat_b;
  logic [1:0]     lat_op;
  logic [IDW-1:0] lat_id;

  // Lowest set request index overall; used directly under fixed priority and
  // as the wrap-around candidate under round-robin.
  logic           lo_found;
  logic [IDW-1:0] lo_id;

`ifdef CMP_ARB_FIXED_PRIO_EN

  // Fixed priority: the lowest set request index always wins.
  always_comb begin
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
    win_found = lo_found;
    win_id    = lo_id;
  end

`else

  // Round-robin pointer: index of the most recent winner. Reset to NREQ-1 so
  // the search after reset starts at index 0.
  logic [IDW-1:0] ptr;

  // Candidates strictly above the pointer, searched before wrapping around.
  logic           hi_found;
  logic [IDW-1:0] hi_id;

  // Round-robin search: the first set request above ptr wins; if none is
  // above ptr, the search wraps and the lowest set request wins.
  always_comb begin
    lo_found = 1'b0;
    lo_id    = '0;
    hi_found = 1'b0;
    hi_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        if (i > int'(ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    win_found = lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  // Pointer advances to the winner on every accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDW'(NREQ - 1);
    end else if (take) begin
      ptr <= win_id;
    end
  end

`endif

  assign win_onehot = {{(NREQ - 1){1'b0}}, 1'b1} << win_id;

  // Operand mux: pull the winner's A, B and opcode out of the packed buses.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_a  = a_bus[4*i +: 4];
        sel_b  = b_bus[4*i +: 4];
        sel_op = op_bus[2*i +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode. Requests are only looked at in IDLE, so a
  // request arriving during BUSY or RESP simply waits.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        finish  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction datapath: operand/id latch, grant pulse, response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= '0;
      lat_id    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (take) begin
        lat_a  <= sel_a;
        lat_b  <= sel_b;
        lat_op <= sel_op;
        lat_id <= win_id;
        gnt    <= win_onehot;
      end
      if (finish) begin
        gnt       <= '0;
        rsp_valid <= 1'b1;
        rsp_id    <= lat_id;
        rsp_data  <= cmp_result;
      end
      if (retire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // The shared unit always sees the last latched operands; they only change
  // when a new request is accepted.
  assign cmp_a     = lat_a;
  assign cmp_b     = lat_b;
  assign cmp_op    = lat_op;
  assign fsm_state = state_q;

endmodule
